// File: rtl/ederah_ctrl_pkg.sv
// Shared address map, CTRL bit positions and FSM encodings for the ederah control slave.
package ederah_ctrl_pkg;

    localparam logic [6:0] ADDR_CTRL           = 7'h00;
    localparam logic [6:0] ADDR_GIE            = 7'h04;
    localparam logic [6:0] ADDR_IER            = 7'h08;
    localparam logic [6:0] ADDR_ISR            = 7'h0C;
    localparam logic [6:0] ADDR_NFADATA_CLS    = 7'h10;
    localparam logic [6:0] ADDR_QUERIES_CLS    = 7'h18;
    localparam logic [6:0] ADDR_RESULTS_CLS    = 7'h20;
    localparam logic [6:0] ADDR_SCALAR03       = 7'h28;
    localparam logic [6:0] ADDR_NFA_HASH_LO    = 7'h30;
    localparam logic [6:0] ADDR_NFA_HASH_HI    = 7'h34;
    localparam logic [6:0] ADDR_NFADATA_PTR_LO = 7'h38;
    localparam logic [6:0] ADDR_NFADATA_PTR_HI = 7'h3C;
    localparam logic [6:0] ADDR_QUERIES_PTR_LO = 7'h40;
    localparam logic [6:0] ADDR_QUERIES_PTR_HI = 7'h44;
    localparam logic [6:0] ADDR_RESULTS_PTR_LO = 7'h48;
    localparam logic [6:0] ADDR_RESULTS_PTR_HI = 7'h4C;
    localparam logic [6:0] ADDR_AXI00_PTR3_LO  = 7'h50;
    localparam logic [6:0] ADDR_AXI00_PTR3_HI  = 7'h54;

    localparam int unsigned CTRL_AP_START     = 0;
    localparam int unsigned CTRL_AP_DONE      = 1;
    localparam int unsigned CTRL_AP_IDLE      = 2;
    localparam int unsigned CTRL_AUTO_RESTART = 7;

    localparam int unsigned NUM_ARG_WORDS = 14;

    typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wr_state_t;
    typedef enum logic       {RDIDLE, RDDATA}         rd_state_t;

    // Word 0..3 are the 32-bit args on an 8-byte pitch, 4..13 the packed 64-bit halves.
    function automatic logic [6:0] arg_addr(input int unsigned idx);
        if (idx < 4) return 7'(32'h10 + idx * 8);
        return 7'(32'h30 + (idx - 4) * 4);
    endfunction

endpackage

// File: rtl/ederah_ctrl_s_axi_if.sv
// AXI4-Lite bus bundle between the control interconnect (master) and ederah_ctrl_s_axi (slave).
interface ederah_ctrl_s_axi_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_bvalid;
    logic                s_axi_bready;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [ADDR_W-1:0]   s_axi_araddr;
    logic                s_axi_rvalid;
    logic                s_axi_rready;
    logic [DATA_W-1:0]   s_axi_rdata;
    logic [1:0]          s_axi_rresp;

    modport master (
        output s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
               s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
               s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );

    modport slave (
        input  s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
               s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
               s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );
endinterface

// File: rtl/ederah_ctrl_reg32.sv
// 32-bit argument register with per-byte write strobes.
module ederah_ctrl_reg32 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] q_o
);
    logic [31:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (we_i) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb_i[b]) q_d[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

// File: rtl/ederah_ctrl_s_axi.sv
// AXI4-Lite control/argument register file for ederah_kernel.
// Optional GIE/IER/ISR and interrupt output: define EDERAH_CTRL_INTERRUPT_EN.
module ederah_ctrl_s_axi
    import ederah_ctrl_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                aclk,
    input  logic                areset,
    ederah_ctrl_s_axi_if.slave  s_axi,
    output logic                interrupt,
    output logic                ap_start,
    input  logic                ap_idle,
    input  logic                ap_done,
    output logic [31:0]         nfadata_cls,
    output logic [31:0]         queries_cls,
    output logic [31:0]         results_cls,
    output logic [31:0]         scalar03,
    output logic [63:0]         nfa_hash,
    output logic [63:0]         nfadata_ptr,
    output logic [63:0]         queries_ptr,
    output logic [63:0]         results_ptr,
    output logic [63:0]         axi00_ptr3
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_width
        $error("ederah_ctrl_s_axi supports only a 32-bit data bus");
    end

    // Holds both ready outputs low until the first edge after reset release.
    logic ready_en_q;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) ready_en_q <= 1'b0;
        else        ready_en_q <= 1'b1;
    end

    wr_state_t       wr_state_q, wr_state_d;
    rd_state_t       rd_state_q, rd_state_d;
    logic [AW-1:0]   waddr_q;
    logic [31:0]     rdata_q, rd_mux;
    logic            aw_hs, w_hs, ar_hs, ctrl_wr, ctrl_rd;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q <= WRIDLE;
            rd_state_q <= RDIDLE;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WRIDLE:  if (aw_hs)               wr_state_d = WRDATA;
            WRDATA:  if (s_axi.s_axi_wvalid)  wr_state_d = WRRESP;
            WRRESP:  if (s_axi.s_axi_bready)  wr_state_d = WRIDLE;
            default:                          wr_state_d = WRIDLE;
        endcase
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RDIDLE:  if (ar_hs)               rd_state_d = RDDATA;
            RDDATA:  if (s_axi.s_axi_rready)  rd_state_d = RDIDLE;
            default:                          rd_state_d = RDIDLE;
        endcase
    end

    always_comb begin
        s_axi.s_axi_awready = ready_en_q && (wr_state_q == WRIDLE);
        s_axi.s_axi_wready  = (wr_state_q == WRDATA);
        s_axi.s_axi_bvalid  = (wr_state_q == WRRESP);
        s_axi.s_axi_bresp   = '0;
        s_axi.s_axi_arready = ready_en_q && (rd_state_q == RDIDLE);
        s_axi.s_axi_rvalid  = (rd_state_q == RDDATA);
        s_axi.s_axi_rdata   = rdata_q;
        s_axi.s_axi_rresp   = '0;
    end

    assign aw_hs   = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
    assign w_hs    = s_axi.s_axi_wvalid  && s_axi.s_axi_wready;
    assign ar_hs   = s_axi.s_axi_arvalid && s_axi.s_axi_arready;
    assign ctrl_wr = w_hs && (waddr_q == AW'(ADDR_CTRL)) && s_axi.s_axi_wstrb[0];
    assign ctrl_rd = ar_hs && (s_axi.s_axi_araddr == AW'(ADDR_CTRL));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)     waddr_q <= '0;
        else if (aw_hs) waddr_q <= s_axi.s_axi_awaddr;
    end

    logic ap_start_q, ap_start_d, auto_restart_q, auto_restart_d, done_q, done_d;

    // Write of 0 drops start; write of 1 only takes effect while the kernel is idle.
    always_comb begin
        ap_start_d     = ap_start_q;
        auto_restart_d = auto_restart_q;
        done_d         = done_q;
        if (ap_done && !auto_restart_q) ap_start_d = 1'b0;
        if (ctrl_wr) begin
            auto_restart_d = s_axi.s_axi_wdata[CTRL_AUTO_RESTART];
            if (!s_axi.s_axi_wdata[CTRL_AP_START]) ap_start_d = 1'b0;
            else if (ap_idle)                      ap_start_d = 1'b1;
        end
        if (ctrl_rd) done_d = 1'b0;
        if (ap_done) done_d = 1'b1;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ap_start_q     <= 1'b0;
            auto_restart_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            ap_start_q     <= ap_start_d;
            auto_restart_q <= auto_restart_d;
            done_q         <= done_d;
        end
    end

    assign ap_start = ap_start_q;

`ifdef EDERAH_CTRL_INTERRUPT_EN
    logic gie_q, ier_q, isr_q, isr_d, irq_q;

    always_comb begin
        isr_d = isr_q;
        if (w_hs && waddr_q == AW'(ADDR_ISR) && s_axi.s_axi_wstrb[0] && s_axi.s_axi_wdata[0])
            isr_d = ~isr_q;
        if (ap_done && ier_q) isr_d = 1'b1;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            gie_q <= 1'b0;
            ier_q <= 1'b0;
            isr_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (w_hs && waddr_q == AW'(ADDR_GIE) && s_axi.s_axi_wstrb[0]) gie_q <= s_axi.s_axi_wdata[0];
            if (w_hs && waddr_q == AW'(ADDR_IER) && s_axi.s_axi_wstrb[0]) ier_q <= s_axi.s_axi_wdata[0];
            isr_q <= isr_d;
            irq_q <= gie_q & isr_q;
        end
    end

    assign interrupt = irq_q;
`else
    assign interrupt = 1'b0;
`endif

    logic [31:0] arg_q [NUM_ARG_WORDS];

    for (genvar g = 0; g < NUM_ARG_WORDS; g++) begin : g_arg
        ederah_ctrl_reg32 u_reg (
            .clk_i   (aclk),
            .rst_i   (areset),
            .we_i    (w_hs && (waddr_q == AW'(arg_addr(g)))),
            .wdata_i (s_axi.s_axi_wdata),
            .wstrb_i (s_axi.s_axi_wstrb),
            .q_o     (arg_q[g])
        );
    end

    assign nfadata_cls = arg_q[0];
    assign queries_cls = arg_q[1];
    assign results_cls = arg_q[2];
    assign scalar03    = arg_q[3];
    assign nfa_hash    = {arg_q[5],  arg_q[4]};
    assign nfadata_ptr = {arg_q[7],  arg_q[6]};
    assign queries_ptr = {arg_q[9],  arg_q[8]};
    assign results_ptr = {arg_q[11], arg_q[10]};
    assign axi00_ptr3  = {arg_q[13], arg_q[12]};

    always_comb begin
        rd_mux = '0;
        if (s_axi.s_axi_araddr == AW'(ADDR_CTRL)) begin
            rd_mux[CTRL_AP_START]     = ap_start_q;
            rd_mux[CTRL_AP_DONE]      = done_q;
            rd_mux[CTRL_AP_IDLE]      = ap_idle;
            rd_mux[CTRL_AUTO_RESTART] = auto_restart_q;
        end
`ifdef EDERAH_CTRL_INTERRUPT_EN
        if (s_axi.s_axi_araddr == AW'(ADDR_GIE)) rd_mux[0] = gie_q;
        if (s_axi.s_axi_araddr == AW'(ADDR_IER)) rd_mux[0] = ier_q;
        if (s_axi.s_axi_araddr == AW'(ADDR_ISR)) rd_mux[0] = isr_q;
`endif
        for (int unsigned i = 0; i < NUM_ARG_WORDS; i++) begin
            if (s_axi.s_axi_araddr == AW'(arg_addr(i))) rd_mux = arg_q[i];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)     rdata_q <= '0;
        else if (ar_hs) rdata_q <= rd_mux;
    end
endmodule

// File: tb/tb_ederah_ctrl_s_axi.sv
// Self-checking bench for ederah_ctrl_s_axi: scoreboard of expected read data plus direct output checks.
module tb_ederah_ctrl_s_axi;
    localparam int unsigned TO = 50;

    logic        aclk = 1'b0;
    logic        areset;
    logic        interrupt, ap_start, ap_idle, ap_done;
    logic [31:0] nfadata_cls, queries_cls, results_cls, scalar03;
    logic [63:0] nfa_hash, nfadata_ptr, queries_ptr, results_ptr, axi00_ptr3;
    logic [31:0] ow [14];
    logic [31:0] sb [$];
    int          checks = 0;
    int          failures = 0;

    ederah_ctrl_s_axi_if bus ();

    ederah_ctrl_s_axi #(.C_S_AXI_ADDR_WIDTH(7), .C_S_AXI_DATA_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset), .s_axi(bus), .interrupt(interrupt),
        .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
        .nfadata_cls(nfadata_cls), .queries_cls(queries_cls), .results_cls(results_cls),
        .scalar03(scalar03), .nfa_hash(nfa_hash), .nfadata_ptr(nfadata_ptr),
        .queries_ptr(queries_ptr), .results_ptr(results_ptr), .axi00_ptr3(axi00_ptr3)
    );

    always #5 aclk = ~aclk;

    always_comb begin
        ow[0]  = nfadata_cls;        ow[1]  = queries_cls;
        ow[2]  = results_cls;        ow[3]  = scalar03;
        ow[4]  = nfa_hash[31:0];     ow[5]  = nfa_hash[63:32];
        ow[6]  = nfadata_ptr[31:0];  ow[7]  = nfadata_ptr[63:32];
        ow[8]  = queries_ptr[31:0];  ow[9]  = queries_ptr[63:32];
        ow[10] = results_ptr[31:0];  ow[11] = results_ptr[63:32];
        ow[12] = axi00_ptr3[31:0];   ow[13] = axi00_ptr3[63:32];
    end

    function automatic logic [6:0] word_addr(input int i);
        logic [6:0] tbl [14];
        tbl = '{7'h10, 7'h18, 7'h20, 7'h28, 7'h30, 7'h34, 7'h38,
                7'h3C, 7'h40, 7'h44, 7'h48, 7'h4C, 7'h50, 7'h54};
        return tbl[i];
    endfunction

    task automatic aw_phase(input logic [6:0] a);
        int unsigned n = 0;
        bus.s_axi_awaddr = a; bus.s_axi_awvalid = 1'b1;
        while (bus.s_axi_awready !== 1'b1 && n < TO) begin @(posedge aclk); #1; n++; end
        checks++;
        if (n >= TO) begin failures++; $display("FAIL aw_timeout awready=%b want=1", bus.s_axi_awready); end
        @(posedge aclk); #1;
        bus.s_axi_awvalid = 1'b0;
    endtask

    task automatic w_phase(input logic [31:0] d, input logic [3:0] s);
        int unsigned n = 0;
        bus.s_axi_wdata = d; bus.s_axi_wstrb = s; bus.s_axi_wvalid = 1'b1;
        while (bus.s_axi_wready !== 1'b1 && n < TO) begin @(posedge aclk); #1; n++; end
        checks++;
        if (n >= TO) begin failures++; $display("FAIL w_timeout wready=%b want=1", bus.s_axi_wready); end
        @(posedge aclk); #1;
        bus.s_axi_wvalid = 1'b0;
    endtask

    task automatic b_phase();
        int unsigned n = 0;
        bus.s_axi_bready = 1'b1;
        while (bus.s_axi_bvalid !== 1'b1 && n < TO) begin @(posedge aclk); #1; n++; end
        checks++;
        if (n >= TO || bus.s_axi_bresp !== 2'b00) begin
            failures++; $display("FAIL b_resp bvalid=%b bresp=%b want=1/00", bus.s_axi_bvalid, bus.s_axi_bresp);
        end
        @(posedge aclk); #1;
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic ar_phase(input logic [6:0] a);
        int unsigned n = 0;
        bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
        while (bus.s_axi_arready !== 1'b1 && n < TO) begin @(posedge aclk); #1; n++; end
        checks++;
        if (n >= TO) begin failures++; $display("FAIL ar_timeout arready=%b want=1", bus.s_axi_arready); end
        @(posedge aclk); #1;
        bus.s_axi_arvalid = 1'b0;
    endtask

    task automatic r_phase(output logic [31:0] d);
        int unsigned n = 0;
        bus.s_axi_rready = 1'b1;
        while (bus.s_axi_rvalid !== 1'b1 && n < TO) begin @(posedge aclk); #1; n++; end
        checks++;
        if (n >= TO || bus.s_axi_rresp !== 2'b00) begin
            failures++; $display("FAIL r_resp rvalid=%b rresp=%b want=1/00", bus.s_axi_rvalid, bus.s_axi_rresp);
        end
        d = bus.s_axi_rdata;
        @(posedge aclk); #1;
        bus.s_axi_rready = 1'b0;
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
        aw_phase(a); w_phase(d, s); b_phase();
    endtask

    task automatic axi_read(input logic [6:0] a, output logic [31:0] d);
        ar_phase(a); r_phase(d);
    endtask

    task automatic pulse_done();
        ap_done = 1'b1;
        @(posedge aclk); #1;
        ap_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got, e;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_bvalid, bus.s_axi_rvalid, ap_start, interrupt} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs aw/ar/b/r/start/irq=%b%b%b%b%b%b want=000000", bus.s_axi_awready,
                     bus.s_axi_arready, bus.s_axi_bvalid, bus.s_axi_rvalid, ap_start, interrupt);
        end
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (ow[i] !== 32'h0) begin failures++; $display("FAIL reset_arg[%0d] got=%h want=0", i, ow[i]); end
        end
        areset = 1'b0;
        #1;
        checks++;
        if (bus.s_axi_awready !== 1'b0) begin failures++; $display("FAIL awready_before_edge got=%b want=0", bus.s_axi_awready); end
        @(posedge aclk); #1;
        checks++;
        if ({bus.s_axi_awready, bus.s_axi_arready} !== 2'b11) begin
            failures++; $display("FAIL ready_after_reset got=%b%b want=11", bus.s_axi_awready, bus.s_axi_arready);
        end
        sb.push_back(32'h0000_0004);
        axi_read(7'h00, got); e = sb.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL reset_ctrl_read got=%h want=%h", got, e); end
    endtask

    task automatic test_wstrb();
        logic [31:0] got, e;
        axi_write(7'h38, 32'h89AB_CDEF, 4'b0011);
        checks++;
        if (nfadata_ptr !== 64'h0000_0000_0000_CDEF) begin
            failures++; $display("FAIL strb_output got=%h want=000000000000cdef", nfadata_ptr);
        end
        sb.push_back(32'h0000_CDEF);
        axi_read(7'h38, got); e = sb.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL strb_read got=%h want=%h", got, e); end
    endtask

    task automatic test_start_done();
        logic [31:0] got, e;
        ap_idle = 1'b1;
        axi_write(7'h00, 32'h1, 4'hF);
        checks++;
        if (ap_start !== 1'b1) begin failures++; $display("FAIL start_set got=%b want=1", ap_start); end
        ap_idle = 1'b0;
        pulse_done();
        checks++;
        if (ap_start !== 1'b0) begin failures++; $display("FAIL start_clear_on_done got=%b want=0", ap_start); end
        ap_idle = 1'b1;
        sb.push_back(32'h0000_0006);
        sb.push_back(32'h0000_0004);
        for (int k = 0; k < 2; k++) begin
            axi_read(7'h00, got); e = sb.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL done_sticky_read%0d got=%h want=%h", k, got, e); end
        end
    endtask

    task automatic test_auto_restart();
        logic [31:0] got, e;
        ap_idle = 1'b1;
        axi_write(7'h00, 32'h81, 4'h1);
        sb.push_back(32'h0000_0085);
        axi_read(7'h00, got); e = sb.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL auto_ctrl_read got=%h want=%h", got, e); end
        ap_idle = 1'b0;
        pulse_done();
        checks++;
        if (ap_start !== 1'b1) begin failures++; $display("FAIL auto_start_held got=%b want=1", ap_start); end
        axi_write(7'h00, 32'h0, 4'h1);
        pulse_done();
        checks++;
        if (ap_start !== 1'b0) begin failures++; $display("FAIL start_after_auto_off got=%b want=0", ap_start); end
        axi_write(7'h00, 32'h1, 4'h1);
        checks++;
        if (ap_start !== 1'b0) begin failures++; $display("FAIL start_ignored_busy got=%b want=0", ap_start); end
        sb.push_back(32'h0000_0002);
        sb.push_back(32'h0000_0000);
        for (int k = 0; k < 2; k++) begin
            axi_read(7'h00, got); e = sb.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL busy_ctrl_read%0d got=%h want=%h", k, got, e); end
        end
        ap_idle = 1'b1;
    endtask

    task automatic test_interrupt();
        logic [31:0] got, e;
        axi_write(7'h04, 32'h1, 4'h1);
        axi_write(7'h08, 32'h1, 4'h1);
        pulse_done();
        repeat (2) @(posedge aclk);
        #1;
`ifdef EDERAH_CTRL_INTERRUPT_EN
        checks++;
        if (interrupt !== 1'b1) begin failures++; $display("FAIL irq_raise got=%b want=1", interrupt); end
        sb.push_back(32'h1);
        axi_read(7'h0C, got); e = sb.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL isr_read got=%h want=%h", got, e); end
        axi_write(7'h0C, 32'h1, 4'h1);
        repeat (2) @(posedge aclk);
        #1;
        checks++;
        if (interrupt !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b want=0", interrupt); end
`else
        checks++;
        if (interrupt !== 1'b0) begin failures++; $display("FAIL irq_tied got=%b want=0", interrupt); end
        for (int k = 0; k < 3; k++) begin
            logic [6:0] a;
            a = 7'(4 + 4 * k);
            sb.push_back(32'h0);
            axi_read(a, got); e = sb.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL irq_reg_absent@%h got=%h want=%h", a, got, e); end
        end
`endif
        sb.push_back(32'h0000_0006);
        axi_read(7'h00, got); e = sb.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL irq_ctrl_read got=%h want=%h", got, e); end
    endtask

    task automatic test_same_cycle_ctrl();
        logic [31:0] got, e;
        ap_idle = 1'b1;
        pulse_done();
        aw_phase(7'h00);
        bus.s_axi_wdata = 32'h1; bus.s_axi_wstrb = 4'h1; bus.s_axi_wvalid = 1'b1;
        bus.s_axi_araddr = 7'h00; bus.s_axi_arvalid = 1'b1;
        checks++;
        if ({bus.s_axi_wready, bus.s_axi_arready} !== 2'b11) begin
            failures++; $display("FAIL same_cycle_ready got=%b%b want=11", bus.s_axi_wready, bus.s_axi_arready);
        end
        @(posedge aclk); #1;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        sb.push_back(32'h0000_0006);
        r_phase(got); e = sb.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL same_cycle_read got=%h want=%h", got, e); end
        b_phase();
        checks++;
        if (ap_start !== 1'b1) begin failures++; $display("FAIL same_cycle_start got=%b want=1", ap_start); end
        sb.push_back(32'h0000_0005);
        axi_read(7'h00, got); e = sb.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL same_cycle_after got=%h want=%h", got, e); end
        ap_idle = 1'b0;
        pulse_done();
        ap_idle = 1'b1;
        sb.push_back(32'h0000_0006);
        axi_read(7'h00, got); e = sb.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL same_cycle_cleanup got=%h want=%h", got, e); end
    endtask

    task automatic test_backpressure();
        logic [31:0] got, e;
        aw_phase(7'h10);
        w_phase(32'hA5A5_0001, 4'hF);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.s_axi_bvalid !== 1'b1) begin failures++; $display("FAIL bvalid_hold%0d got=%b want=1", k, bus.s_axi_bvalid); end
            @(posedge aclk); #1;
        end
        b_phase();
        checks++;
        if (nfadata_cls !== 32'hA5A5_0001) begin failures++; $display("FAIL bp_output got=%h want=a5a50001", nfadata_cls); end
        ar_phase(7'h10);
        sb.push_back(32'hA5A5_0001);
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.s_axi_rvalid !== 1'b1 || bus.s_axi_rdata !== e) begin
                failures++; $display("FAIL rdata_hold%0d rvalid=%b rdata=%h want=1/%h", k, bus.s_axi_rvalid, bus.s_axi_rdata, e);
            end
            @(posedge aclk); #1;
        end
        r_phase(got);
        checks++;
        if (got !== e) begin failures++; $display("FAIL bp_read got=%h want=%h", got, e); end
    endtask

    task automatic test_reset_midflight();
        aw_phase(7'h40);
        w_phase(32'h1234_5678, 4'hF);
        ar_phase(7'h40);
        checks++;
        if ({bus.s_axi_bvalid, bus.s_axi_rvalid} !== 2'b11 || bus.s_axi_rdata !== 32'h1234_5678) begin
            failures++; $display("FAIL midflight_pending b/r=%b%b rdata=%h want=11/12345678",
                                 bus.s_axi_bvalid, bus.s_axi_rvalid, bus.s_axi_rdata);
        end
        areset = 1'b1;
        #1;
        checks++;
        if ({bus.s_axi_bvalid, bus.s_axi_rvalid, bus.s_axi_awready} !== 3'b000 || bus.s_axi_rdata !== 32'h0) begin
            failures++; $display("FAIL midflight_drop b/r/aw=%b%b%b rdata=%h want=000/0", bus.s_axi_bvalid,
                                 bus.s_axi_rvalid, bus.s_axi_awready, bus.s_axi_rdata);
        end
        checks++;
        if (queries_ptr !== 64'h0 || nfadata_cls !== 32'h0) begin
            failures++; $display("FAIL midflight_regs queries_ptr=%h nfadata_cls=%h want=0/0", queries_ptr, nfadata_cls);
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, e, d [14];
        for (int i = 0; i < 14; i++) begin
            d[i] = 32'hC000_0001 + 32'(i) * 32'h0011_0011;
            axi_write(word_addr(i), d[i], 4'hF);
        end
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (ow[i] !== d[i]) begin failures++; $display("FAIL b2b_output[%0d] got=%h want=%h", i, ow[i], d[i]); end
        end
        checks++;
        if (axi00_ptr3 !== {d[13], d[12]}) begin failures++; $display("FAIL b2b_ptr64 got=%h want=%h%h", axi00_ptr3, d[13], d[12]); end
        for (int i = 0; i < 14; i++) sb.push_back(d[i]);
        for (int i = 0; i < 14; i++) begin
            axi_read(word_addr(i), got); e = sb.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL b2b_read[%0d] got=%h want=%h", i, got, e); end
        end
        axi_write(7'h28, 32'hFFFF_FFFF, 4'b1010);
        e = (d[3] & 32'h00FF_00FF) | 32'hFF00_FF00;
        checks++;
        if (scalar03 !== e) begin failures++; $display("FAIL partial_strb got=%h want=%h", scalar03, e); end
        axi_write(7'h58, 32'hDEAD_BEEF, 4'hF);
        axi_write(7'h7C, 32'hDEAD_BEEF, 4'hF);
        sb.push_back(32'h0);
        sb.push_back(32'h0);
        axi_read(7'h58, got); e = sb.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL unmapped58 got=%h want=%h", got, e); end
        axi_read(7'h7C, got); e = sb.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL unmapped7c got=%h want=%h", got, e); end
    endtask

    initial begin
        areset = 1'b1; ap_idle = 1'b1; ap_done = 1'b0;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_awaddr = '0;
        bus.s_axi_wvalid = 1'b0;  bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_arvalid = 1'b0; bus.s_axi_araddr = '0;
        bus.s_axi_rready = 1'b0;
        test_reset();
        test_wstrb();
        test_start_done();
        test_auto_restart();
        test_interrupt();
        test_same_cycle_ctrl();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
